spi_flash_slave: RTL and testbench

- Synthesizable SPI NOR-flash responder (mode 0: CPOL=0, CPHA=0) that answers the SPI master side of the flash drive stack.
- Oversamples SCK/CS/MOSI on the system clock and decodes a subset of flash commands: WREN, WRDI, RDSR, READ, PP and CE.
- Backs the commands with an internal byte RAM and a status register.
- Serves as the on-chip loopback target and simulation partner for the flash master.

---
 rtl/spi_flash_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_slave.sv
// SPI mode-0 NOR-flash responder (WREN/WRDI/RDSR/READ/PP/CE) backed by an internal byte RAM.
// Pins are seen P_SYNC_STAGES+1 clocks late; no backpressure, so SCK must stay at or below i_clk/8.
module spi_flash_slave #(
    parameter int P_MEM_DEPTH   = 256,
    parameter int P_PP_BUSY     = 64,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_busy,
    output logic [7:0] o_cmd,
    output logic       o_cmd_valid
);

    localparam int AW = $clog2(P_MEM_DEPTH);
    localparam int BW = $clog2(P_PP_BUSY + 1);

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_CE   = 8'hC7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_STATUS, ST_WAIT_CS, ST_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [P_SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic        sck_s, cs_s, mosi_s, sck_d, cs_d;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;
    logic [4:0]  bit_cnt;
    logic [3:0]  bit_total;
    logic [2:0]  out_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  rx_byte, tx_sh, op_q, cmd_q, status;
    logic        cmd_vld_q, op_vld, commit_q, miso_q;
    logic [23:0] addr, addr_shift, addr_inc;
    logic        wel, wip, erase_act;
    logic [AW-1:0] erase_addr;
    logic [BW-1:0] busy_cnt;
    logic        cmd_last, addr_last, wr_byte;

    logic [7:0]    mem [P_MEM_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [7:0]    mem_wd;

    // Sync chain resets low so a CS held low across reset never looks like a fresh select.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0], i_spi_clk};
            cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0], i_spi_cs};
            mosi_sync <= {mosi_sync[P_SYNC_STAGES-2:0], i_spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s      = sck_sync[P_SYNC_STAGES-1];
    assign cs_s       = cs_sync[P_SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[P_SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign cs_rise    = cs_s & ~cs_d;
    assign cs_fall    = ~cs_s & cs_d;
    assign rx_byte    = {rx_sh, mosi_s};
    assign addr_shift = {addr[22:0], mosi_s};
    assign addr_inc   = addr + 24'd1;
    assign status     = {6'b0, wel, wip};
    assign cmd_last   = sck_rise && (state == ST_CMD) && (bit_cnt == 5'd7);
    assign addr_last  = sck_rise && (state == ST_ADDR) && (bit_cnt == 5'd23);
    assign wr_byte    = sck_rise && (state == ST_WDATA) && (bit_cnt[2:0] == 3'd7);

    function automatic state_t decode_op(input logic [7:0] op, input logic busy);
        state_t s;
        s = ST_IGNORE;
        if (busy) begin
            if (op == OP_RDSR) s = ST_STATUS;
        end else begin
            case (op)
                OP_WREN, OP_WRDI, OP_CE: s = ST_WAIT_CS;
                OP_RDSR:                 s = ST_STATUS;
                OP_READ, OP_PP:          s = ST_ADDR;
                default:                 s = ST_IGNORE;
            endcase
        end
        return s;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall)   state_nxt = ST_CMD;
                ST_CMD:  if (cmd_last)  state_nxt = decode_op(rx_byte, wip);
                ST_ADDR: if (addr_last) state_nxt = (op_q == OP_READ) ? ST_RDATA : ST_WDATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_spi_miso  = ((state == ST_RDATA) || (state == ST_STATUS)) ? miso_q : 1'b0;
        o_busy      = wip;
        o_cmd       = cmd_q;
        o_cmd_valid = cmd_vld_q;
    end

    // Single write port: the erase sweep always beats a page-program byte.
    always_comb begin
        mem_we = erase_act || (wr_byte && wel);
        mem_wa = erase_act ? erase_addr : addr[AW-1:0];
        mem_wd = erase_act ? 8'hFF : rx_byte;
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt    <= '0;
            bit_total  <= '0;
            out_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            miso_q     <= 1'b0;
            addr       <= '0;
            op_q       <= '0;
            op_vld     <= 1'b0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            commit_q   <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            busy_cnt   <= '0;
            erase_act  <= 1'b0;
            erase_addr <= '0;
        end else begin
            cmd_vld_q <= 1'b0;
            commit_q  <= cs_rise;

            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BW'(1);
                if (busy_cnt == BW'(1)) wip <= 1'b0;
            end
            if (erase_act) begin
                erase_addr <= erase_addr + AW'(1);
                if (erase_addr == AW'(P_MEM_DEPTH - 1)) begin
                    erase_act <= 1'b0;
                    wip       <= 1'b0;
                end
            end

            // Commit one cycle after CS rise so a byte finishing on that same cycle is counted.
            if (commit_q && op_vld) begin
                op_vld <= 1'b0;
                case (op_q)
                    OP_WREN: if (bit_total == 4'd8) wel <= 1'b1;
                    OP_WRDI: if (bit_total == 4'd8) wel <= 1'b0;
                    OP_PP: if (wel) begin
                        wel      <= 1'b0;
                        wip      <= 1'b1;
                        busy_cnt <= BW'(P_PP_BUSY);
                    end
                    OP_CE: if (wel && (bit_total == 4'd8)) begin
                        wel        <= 1'b0;
                        wip        <= 1'b1;
                        erase_act  <= 1'b1;
                        erase_addr <= '0;
                    end
                    default: ;
                endcase
            end

            if ((state == ST_IDLE) && cs_fall) begin
                bit_total <= '0;
                op_vld    <= 1'b0;
            end

            if (sck_rise && (state != ST_IDLE)) begin
                rx_sh <= rx_byte[6:0];
                if (bit_total != 4'hF) bit_total <= bit_total + 4'd1;
                case (state)
                    ST_CMD: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt   <= '0;
                            cmd_q     <= rx_byte;
                            cmd_vld_q <= 1'b1;
                            op_q      <= rx_byte;
                            op_vld    <= !wip || (rx_byte == OP_RDSR);
                            tx_sh     <= status;
                            out_cnt   <= '0;
                        end
                    end
                    ST_ADDR: begin
                        addr    <= addr_shift;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            tx_sh   <= mem[addr_shift[AW-1:0]];
                            out_cnt <= '0;
                        end
                    end
                    ST_WDATA: begin
                        bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        if (bit_cnt[2:0] == 3'd7) addr <= {addr[23:8], addr[7:0] + 8'd1};
                    end
                    default: ;
                endcase
            end

            if (sck_fall && !cs_s && ((state == ST_RDATA) || (state == ST_STATUS))) begin
                miso_q  <= tx_sh[7];
                out_cnt <= out_cnt + 3'd1;
                if (out_cnt == 3'd7) begin
                    if (state == ST_RDATA) begin
                        addr  <= addr_inc;
                        tx_sh <= mem[addr_inc[AW-1:0]];
                    end else begin
                        tx_sh <= status;
                    end
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end

            if (cs_s) begin
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Scoreboard bench for spi_flash_slave: bit-banged SPI master plus a small RAM/status model.
module tb_spi_flash_slave;

    localparam int H       = 6;
    localparam int PP_BUSY = 300;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_spi_clk = 1'b0;
    logic       i_spi_cs = 1'b1;
    logic       i_spi_mosi = 1'b0;
    logic       o_spi_miso, o_busy, o_cmd_valid;
    logic [7:0] o_cmd;

    always #5 i_clk = ~i_clk;

    spi_flash_slave #(
        .P_MEM_DEPTH  (256),
        .P_PP_BUSY    (PP_BUSY),
        .P_SYNC_STAGES(2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_spi_clk  (i_spi_clk),
        .i_spi_cs   (i_spi_cs),
        .i_spi_mosi (i_spi_mosi),
        .o_spi_miso (o_spi_miso),
        .o_busy     (o_busy),
        .o_cmd      (o_cmd),
        .o_cmd_valid(o_cmd_valid)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_total = 0;
    int         cv_total = 0;
    logic [7:0] md [256];
    logic [7:0] sr_m;
    logic [7:0] sb [$];

    always @(negedge i_clk) begin
        if (o_busy)      busy_total++;
        if (o_cmd_valid) cv_total++;
    end

    initial begin
        repeat (150000) @(posedge i_clk);
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] got);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            check_val(tag, {24'd0, got}, {24'd0, exp});
        end
    endtask

    task automatic sck_bit(input logic b, output logic r);
        i_spi_mosi = b;
        repeat (H) @(negedge i_clk);
        r = o_spi_miso;
        i_spi_clk = 1'b1;
        repeat (H) @(negedge i_clk);
        i_spi_clk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_lo();
        @(negedge i_clk);
        i_spi_cs = 1'b0;
        repeat (H) @(negedge i_clk);
    endtask

    task automatic cs_hi();
        repeat (H) @(negedge i_clk);
        i_spi_cs = 1'b1;
        repeat (2 * H) @(negedge i_clk);
    endtask

    task automatic send_cmd(input logic [7:0] op);
        logic [7:0] r;
        cs_lo();
        xfer(op, r);
        cs_hi();
    endtask

    task automatic rdsr_check(input string tag);
        logic [7:0] r;
        sb.push_back(sr_m);
        cs_lo();
        xfer(8'h05, r);
        xfer(8'h00, r);
        sb_check(tag, r);
        cs_hi();
    endtask

    task automatic read_bytes(input logic [23:0] a, input int n);
        logic [7:0] r;
        logic [7:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = a[7:0] + 8'(i);
            sb.push_back(md[idx]);
        end
        cs_lo();
        xfer(8'h03, r);
        xfer(a[23:16], r);
        xfer(a[15:8], r);
        xfer(a[7:0], r);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, r);
            sb_check("read_data", r);
        end
        cs_hi();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!o_busy) break;
            @(negedge i_clk);
        end
        check_val("busy_release", {31'd0, o_busy}, 0);
    endtask

    initial begin
        logic [7:0] r;
        logic       b, seen;
        int         b0, c0;

        sr_m = 8'h00;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check_val("rst_miso", {31'd0, o_spi_miso}, 0);
        check_val("rst_busy", {31'd0, o_busy}, 0);
        check_val("rst_cmd", {24'd0, o_cmd}, 0);
        check_val("rst_cmd_valid", {31'd0, o_cmd_valid}, 0);

        rdsr_check("rdsr_reset");
        send_cmd(8'h06);
        sr_m = 8'h02;
        rdsr_check("rdsr_wren");
        send_cmd(8'h04);
        sr_m = 8'h00;
        rdsr_check("rdsr_wrdi");

        // Nine clocks on WREN must not latch WEL.
        cs_lo();
        xfer(8'h06, r);
        sck_bit(1'b0, b);
        cs_hi();
        rdsr_check("rdsr_wren_9bits");

        // Chip erase, with a READ attempted inside the busy window.
        send_cmd(8'h06);
        b0 = busy_total;
        send_cmd(8'hC7);
        c0 = cv_total;
        cs_lo();
        xfer(8'h03, r);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, r);
            check_val("busy_read_miso", {24'd0, r}, 0);
        end
        check_val("busy_read_cmd_valid", cv_total - c0, 1);
        check_val("busy_read_cmd", {24'd0, o_cmd}, 32'h03);
        cs_hi();
        wait_idle();
        check_val("ce_busy_cycles", busy_total - b0, 256);
        for (int i = 0; i < 256; i++) md[i] = 8'hFF;
        rdsr_check("rdsr_after_ce");
        read_bytes(24'h000000, 256);

        // Page program across the page end, then poll status through the busy window.
        send_cmd(8'h06);
        b0 = busy_total;
        cs_lo();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'hFE, r);
        xfer(8'hA1, r);
        xfer(8'hA2, r);
        xfer(8'hA3, r);
        xfer(8'hA4, r);
        cs_hi();
        md[8'hFE] = 8'hA1;
        md[8'hFF] = 8'hA2;
        md[8'h00] = 8'hA3;
        md[8'h01] = 8'hA4;
        cs_lo();
        xfer(8'h05, r);
        xfer(8'h00, r);
        check_val("pp_poll_first", {24'd0, r}, 32'h01);
        seen = (r == 8'h00);
        for (int k = 0; k < 8 && !seen; k++) begin
            xfer(8'h00, r);
            if (r == 8'h00) seen = 1'b1;
            else check_val("pp_poll_busy", {24'd0, r}, 32'h01);
        end
        check_val("pp_poll_cleared", {31'd0, seen}, 1);
        cs_hi();
        wait_idle();
        check_val("pp_busy_cycles", busy_total - b0, PP_BUSY);
        read_bytes(24'h0000FE, 4);

        // Page program without WEL: no write, no busy.
        cs_lo();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h10, r);
        xfer(8'h55, r);
        cs_hi();
        repeat (10) @(negedge i_clk);
        check_val("pp_nowel_busy", {31'd0, o_busy}, 0);
        read_bytes(24'h000010, 1);
        rdsr_check("rdsr_pp_nowel");

        // Unknown opcode with WEL held: silent, status untouched.
        send_cmd(8'h06);
        sr_m = 8'h02;
        cs_lo();
        xfer(8'h9F, r);
        xfer(8'h00, r);
        check_val("unknown_miso0", {24'd0, r}, 0);
        xfer(8'hAA, r);
        check_val("unknown_miso1", {24'd0, r}, 0);
        cs_hi();
        rdsr_check("rdsr_unknown");

        // Reset in the middle of a READ while CS stays low.
        cs_lo();
        xfer(8'h03, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        sb.push_back(md[8'h00]);
        xfer(8'h00, r);
        sb_check("pre_reset_read", r);
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_val("midrst_miso", {31'd0, o_spi_miso}, 0);
        check_val("midrst_busy", {31'd0, o_busy}, 0);
        check_val("midrst_cmd", {24'd0, o_cmd}, 0);
        c0 = cv_total;
        xfer(8'h05, r);
        check_val("midrst_ign_miso0", {24'd0, r}, 0);
        xfer(8'h00, r);
        check_val("midrst_ign_miso1", {24'd0, r}, 0);
        check_val("midrst_no_cmd_valid", cv_total - c0, 0);
        cs_hi();
        sr_m = 8'h00;
        rdsr_check("rdsr_after_midrst");
        read_bytes(24'h0000FE, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
